// File: rtl/btn_debounce_bank_pkg.sv
// Shared types and defaults for the button debounce bank.
// Holds the FSM state encoding, default parameters and the counter-width check.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } btn_state_t;

    localparam int unsigned N_CH_DEF          = 32'd5;
    localparam int unsigned DEB_CYCLES_DEF    = 32'd1000000;
    localparam int unsigned HOLD_CYCLES_DEF   = 32'd50000000;
    localparam int unsigned REPEAT_CYCLES_DEF = 32'd10000000;
    localparam int unsigned CNT_W_DEF         = 32'd26;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when max_val fits in cnt_w unsigned bits, i.e. 2^cnt_w > max_val.
    function automatic bit cnt_fits(input int unsigned cnt_w,
                                    input int unsigned max_val);
        return ($clog2(max_val + 32'd1) <= cnt_w);
    endfunction

endpackage

// File: rtl/btn_debounce_bank_if.sv
// Pad-side and MMIO-side signal bundle of the button debounce bank.
// master drives the raw pads and clears; slave is the debounce bank.
interface btn_debounce_bank_if #(
    parameter int unsigned N_CH = btn_pkg::N_CH_DEF
) ();

    logic [N_CH-1:0] key_in;
    logic [N_CH-1:0] evt_clr;
    logic [N_CH-1:0] key_level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_press;
    logic [N_CH-1:0] evt_pending;
    logic            evt_any;

    modport master (
        output key_in, evt_clr,
        input  key_level, press_pulse, release_pulse, long_press, evt_pending, evt_any
    );

    modport slave (
        input  key_in, evt_clr,
        output key_level, press_pulse, release_pulse, long_press, evt_pending, evt_any
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold/long-press timing, sticky event.
// Auto-repeat of press_pulse while long-pressed is built only with BTN_AUTO_REPEAT_EN defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key,
    input  logic i_evt_clr,
    output logic o_key_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_press,
    output logic o_evt_pending
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    if (DEB_CYCLES < 32'd2) begin : g_bad_deb
        $error("btn_debounce_ch: DEB_CYCLES must be at least 2");
    end
    if (HOLD_CYCLES <= DEB_CYCLES) begin : g_bad_hold
        $error("btn_debounce_ch: HOLD_CYCLES must exceed DEB_CYCLES");
    end
    if (!cnt_fits(CNT_W, max3(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES))) begin : g_bad_w
        $error("btn_debounce_ch: CNT_W too narrow for the configured cycle counts");
    end

    logic [1:0]       r_sync;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold;
    logic             r_key_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_evt;

    logic             w_s;
    logic [CNT_W-1:0] w_hold_inc;
    logic             w_hold_hit;
    logic             w_rel_done;
    logic             w_held;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES);
    logic [CNT_W-1:0] r_rep;
    logic [CNT_W-1:0] w_rep_inc;
    logic             w_rep_fire;
`endif

    // Two-flop synchroniser for the asynchronous pad.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_key};
        end
    end

    // Next-value helpers; w_held covers every cycle the accepted level stays high.
    always_comb begin
        w_s        = r_sync[1];
        w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : (r_hold + CNT_ONE);
        w_hold_hit = (w_hold_inc == HOLD_MAX);
        w_rel_done = (r_state == S_CHK_L) && !w_s && (r_cnt == DEB_LAST);
        w_held     = (r_state == S_HIGH) || ((r_state == S_CHK_L) && !w_rel_done);
`ifdef BTN_AUTO_REPEAT_EN
        w_rep_inc  = r_rep + CNT_ONE;
        w_rep_fire = r_long && (w_rep_inc == REP_MAX);
`endif
    end

    // Debounce FSM with registered pulses, hold timing and sticky event flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_LOW;
            r_cnt       <= CNT_ZERO;
            r_hold      <= CNT_ZERO;
            r_key_level <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_evt       <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            r_rep       <= CNT_ZERO;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            // A press later in this block overrides the clear, so set wins.
            if (i_evt_clr) begin
                r_evt <= 1'b0;
            end

            case (r_state)
                S_LOW: begin
                    if (w_s) begin
                        r_state <= S_CHK_H;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                S_CHK_H: begin
                    if (!w_s) begin
                        r_state <= S_LOW;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state     <= S_HIGH;
                        r_cnt       <= CNT_ZERO;
                        r_key_level <= 1'b1;
                        r_press     <= 1'b1;
                        r_evt       <= 1'b1;
                        r_hold      <= CNT_ZERO;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!w_s) begin
                        r_state <= S_CHK_L;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                S_CHK_L: begin
                    if (w_s) begin
                        r_state <= S_HIGH;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state     <= S_LOW;
                        r_cnt       <= CNT_ZERO;
                        r_key_level <= 1'b0;
                        r_long      <= 1'b0;
                        r_release   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= CNT_ZERO;
                end
            endcase

            // Hold timing runs through release bounces so they do not restart long-press.
            if (w_held) begin
                r_hold <= w_hold_inc;
                if (w_hold_hit) begin
                    r_long <= 1'b1;
                end
            end

`ifdef BTN_AUTO_REPEAT_EN
            if (w_held && r_long) begin
                if (w_rep_fire) begin
                    r_rep   <= CNT_ZERO;
                    r_press <= 1'b1;
                    r_evt   <= 1'b1;
                end else begin
                    r_rep   <= w_rep_inc;
                end
            end else begin
                r_rep <= CNT_ZERO;
            end
`endif
        end
    end

    assign o_key_level     = r_key_level;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_long_press    = r_long;
    assign o_evt_pending   = r_evt;

endmodule

// File: rtl/btn_debounce_bank.sv
// N-channel button conditioner: one btn_debounce_ch per pad plus a registered evt_any.
// Defining BTN_AUTO_REPEAT_EN enables auto-repeat press pulses while long-pressed.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int unsigned N_CH          = N_CH_DEF,
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    btn_debounce_bank_if.slave  bus
);

    logic [N_CH-1:0] w_key_level;
    logic [N_CH-1:0] w_press_pulse;
    logic [N_CH-1:0] w_release_pulse;
    logic [N_CH-1:0] w_long_press;
    logic [N_CH-1:0] w_evt_pending;
    logic            r_evt_any;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .i_clk           (clk),
            .i_rstn          (rstn),
            .i_key           (bus.key_in[g]),
            .i_evt_clr       (bus.evt_clr[g]),
            .o_key_level     (w_key_level[g]),
            .o_press_pulse   (w_press_pulse[g]),
            .o_release_pulse (w_release_pulse[g]),
            .o_long_press    (w_long_press[g]),
            .o_evt_pending   (w_evt_pending[g])
        );
    end

    // Summary interrupt-style flag, one cycle behind the per-channel flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_evt_any <= 1'b0;
        end else begin
            r_evt_any <= |w_evt_pending;
        end
    end

    assign bus.key_level     = w_key_level;
    assign bus.press_pulse   = w_press_pulse;
    assign bus.release_pulse = w_release_pulse;
    assign bus.long_press    = w_long_press;
    assign bus.evt_pending   = w_evt_pending;
    assign bus.evt_any       = r_evt_any;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: directed scenarios plus random pad activity,
// compared each cycle against a behavioural model of the debounce rules.
module tb_btn_debounce_bank;

    localparam int NC   = 3;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int CW   = 8;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int EXP_PRESS2 = 3;
`else
    localparam int EXP_PRESS2 = 1;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_bank_if #(.N_CH(NC)) bus ();

    btn_debounce_bank #(
        .N_CH          (NC),
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Model: pad delay line, accepted level, run of disagreeing samples, age since press.
    logic [NC-1:0] p1, p2, m_lvl, m_long, m_evt, e_press, e_rel;
    logic          e_any;
    int            m_run [NC];
    int            m_age [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic void model_reset();
        p1 = '0; p2 = '0; m_lvl = '0; m_long = '0; m_evt = '0;
        e_press = '0; e_rel = '0; e_any = 1'b0;
        for (int c = 0; c < NC; c++) begin
            m_run[c] = 0;
            m_age[c] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [NC-1:0] ki, input logic [NC-1:0] clr);
        e_any = |m_evt;
        for (int c = 0; c < NC; c++) begin
            logic s;
            s      = p2[c];
            p2[c]  = p1[c];
            p1[c]  = ki[c];
            e_press[c] = 1'b0;
            e_rel[c]   = 1'b0;
            if (s != m_lvl[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == DEB) begin
                m_run[c] = 0;
                m_lvl[c] = s;
                if (s) begin
                    e_press[c] = 1'b1;
                    m_age[c]   = 0;
                end else begin
                    e_rel[c]  = 1'b1;
                    m_long[c] = 1'b0;
                end
            end else if (m_lvl[c]) begin
                m_age[c]++;
                if (m_age[c] >= HOLD) m_long[c] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                if ((m_age[c] > HOLD) && (((m_age[c] - HOLD) % REP) == 0)) e_press[c] = 1'b1;
`endif
            end
            if (e_press[c]) m_evt[c] = 1'b1;
            else if (clr[c]) m_evt[c] = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(bus.key_in, bus.evt_clr);
        #1;
        cyc++;
        chk("key_level",     32'(bus.key_level),     32'(m_lvl));
        chk("press_pulse",   32'(bus.press_pulse),   32'(e_press));
        chk("release_pulse", 32'(bus.release_pulse), 32'(e_rel));
        chk("long_press",    32'(bus.long_press),    32'(m_long));
        chk("evt_pending",   32'(bus.evt_pending),   32'(m_evt));
        chk("evt_any",       32'(bus.evt_any),       32'(e_any));
    endtask

    initial begin
        int level_at, long_at, rel_at, n_press1, n_press2;
        logic [7:0] bounce;

        // Reset with all pads held high.
        model_reset();
        bus.key_in  = 3'b111;
        bus.evt_clr = 3'b000;
        rstn        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level",   32'(bus.key_level),   32'd0);
        chk("reset_press",   32'(bus.press_pulse), 32'd0);
        chk("reset_long",    32'(bus.long_press),  32'd0);
        chk("reset_evt",     32'(bus.evt_pending), 32'd0);
        chk("reset_evt_any", 32'(bus.evt_any),     32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_release_quiet", 32'(bus.press_pulse | bus.key_level), 32'd0);
        end
        step();
        chk("rst_accept_level", 32'(bus.key_level),   32'd7);
        chk("rst_accept_press", 32'(bus.press_pulse), 32'd7);
        step();
        chk("rst_press_once", 32'(bus.press_pulse), 32'd0);

        // Release everything and clear the flags.
        bus.key_in  = 3'b000;
        bus.evt_clr = 3'b111;
        step();
        bus.evt_clr = 3'b000;
        repeat (8) step();
        chk("idle_evt", 32'(bus.evt_pending), 32'd0);

        // Clean press on ch0 with clear racing the press edge.
        bus.key_in[0] = 1'b1;
        repeat (5) step();
        bus.evt_clr[0] = 1'b1;
        step();
        chk("clean_press",      32'(bus.press_pulse[0]), 32'd1);
        chk("clean_level",      32'(bus.key_level[0]),   32'd1);
        chk("clr_race_set_wins", 32'(bus.evt_pending[0]), 32'd1);
        step();
        chk("clr_late_clears", 32'(bus.evt_pending[0]), 32'd0);
        chk("evt_any_lag",     32'(bus.evt_any),        32'd1);
        bus.evt_clr[0] = 1'b0;
        bus.key_in[0]  = 1'b0;
        repeat (8) step();

        // Bounce rejection on ch1, then a stable press.
        bounce   = 8'b0111_0111;
        n_press1 = 0;
        for (int i = 0; i < 12; i++) begin
            bus.key_in[1] = (i < 8) ? bounce[i] : 1'b0;
            step();
            n_press1 += int'(bus.press_pulse[1]);
            chk("bounce_level", 32'(bus.key_level[1]), 32'd0);
        end
        chk("bounce_no_press", 32'(n_press1), 32'd0);
        bus.key_in[1] = 1'b1;
        repeat (6) step();
        chk("bounce_then_accept", 32'(bus.key_level[1]), 32'd1);
        bus.key_in[1] = 1'b0;
        repeat (8) step();

        // Long press on ch2 for 40 cycles, then release.
        level_at = -1; long_at = -1; rel_at = -1; n_press2 = 0;
        bus.key_in[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_press2 += int'(bus.press_pulse[2]);
            if (bus.key_level[2] && level_at < 0) level_at = i;
            if (bus.long_press[2] && long_at < 0) long_at = i;
        end
        chk("long_delay", 32'(long_at - level_at), 32'd20);
        bus.key_in[2] = 1'b0;
        for (int i = 0; i < 20 && rel_at < 0; i++) begin
            step();
            n_press2 += int'(bus.press_pulse[2]);
            if (bus.release_pulse[2]) begin
                rel_at = i;
                chk("long_drops_on_release", 32'(bus.long_press[2]), 32'd0);
            end
        end
        chk("release_latency", 32'(rel_at),   32'd5);
        chk("press_count_ch2", 32'(n_press2), 32'(EXP_PRESS2));
        repeat (4) step();

        // Random pad activity: bouncy first, then long holds.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, (i < 700) ? 5 : 39) == 0) bus.key_in[c] = ~bus.key_in[c];
                bus.evt_clr[c] = ($urandom_range(0, 5) == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/btn_debounce_bank.md
Name: btn_debounce_bank

Overview:
- Parametrised N-channel button conditioner. Replaces the per-button single-channel debouncers in the top level with one bank.
- Each channel provides:
  - synchronisation of the raw pad input
  - a debounced level
  - press/release pulses
  - long-press detection
  - a sticky event flag that the CPU's MMIO path polls and clears.
- Sits between the board button pads and MemOrIO / Debug_Controller.

Parameters:
- N_CH, 5, number of button channels
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2
- HOLD_CYCLES, 50000000, debounced-high cycles before long_press asserts; must be > DEB_CYCLES
- REPEAT_CYCLES, 10000000, auto-repeat period (used only with the optional feature)
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)

Ports:
- clk  in  1  single system clock; every flop is on its rising edge
- rstn  in  1  asynchronous active-low reset
- key_in  in  N_CH  raw asynchronous button pads, active-high
- evt_clr  in  N_CH  per-channel clear of evt_pending, sampled on clk
- key_level  out  N_CH  debounced level
- press_pulse  out  N_CH  one-cycle pulse on accepted press (and on each repeat when the optional feature is enabled)
- release_pulse  out  N_CH  one-cycle pulse on accepted release
- long_press  out  N_CH  level; high while held at least HOLD_CYCLES
- evt_pending  out  N_CH  sticky flag, set by press_pulse
- evt_any  out  1  OR-reduction of evt_pending, registered

Behaviour:
- Reset (rstn low, asynchronous):
  - synchroniser flops, counters and FSM cleared
  - all outputs 0; FSM in S_LOW
  - no pulses are generated on reset release, even if key_in is held high; the press is accepted after normal debounce.
- Synchroniser: two-flop chain per channel. s = output of the second flop.
- Debounce FSM, per channel:
  - S_LOW: if s=1, go to S_CHK_H with cnt=1.
  - S_CHK_H:
    - s=0: return to S_LOW, cnt=0.
    - s=1 and cnt=DEB_CYCLES-1: go to S_HIGH; key_level<=1; press_pulse<=1 for one cycle; hold counter cleared.
    - otherwise: cnt+1.
  - S_HIGH: if s=0, go to S_CHK_L with cnt=1. The hold counter increments each cycle, saturating at HOLD_CYCLES. long_press<=1 on the edge where the hold counter reaches HOLD_CYCLES.
  - S_CHK_L: mirror of S_CHK_H.
    - s=1: return to S_HIGH; the hold counter keeps counting (a bounce does not restart long-press timing).
    - completion: go to S_LOW; key_level<=0; long_press<=0; release_pulse<=1 for one cycle.
- Latency: let edge k be the first edge whose key_in sample holds the new value, with the input stable from then on. key_level and the pulse change on edge k+DEB_CYCLES+1.
- Any bounce during a CHK state restarts acceptance from zero.
- Pulse outputs are registered and asserted for exactly one cycle.
- evt_pending:
  - set on the cycle press_pulse is asserted
  - cleared on an edge where evt_clr is 1 and no press_pulse occurs
  - simultaneous set and clear: set wins.
- evt_any lags evt_pending by one cycle.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Counter arithmetic is unsigned CNT_W, with no wrap. The hold counter saturates.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: once long_press is high, a repeat counter runs in S_HIGH (and through S_CHK_L bounces).
  - Each time it reaches REPEAT_CYCLES it reloads to 0, asserts press_pulse for one cycle and sets evt_pending.
  - The first repeat occurs REPEAT_CYCLES cycles after long_press rises.
  - No repeat is issued in the cycle where release is accepted.
- Undefined: the repeat counter and logic are absent; press_pulse fires only once per accepted press.

Decomposition:
- Package btn_pkg:
  - FSM state enum {S_LOW, S_CHK_H, S_HIGH, S_CHK_L}, 2-bit encoding
  - default parameter constants
  - clog2-based width-check function used in elaboration assertions.
- Sub-module btn_debounce_ch: one channel (synchroniser, FSM, counters, evt flag), generated N_CH times.
- The bank contains only the generate loop and the evt_any register.

Test Plan (bench with DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, N_CH=3):
- Reset behaviour: hold key_in=3'b111 through reset, release rstn at edge 0. All outputs are 0 until edge 5, then key_level=3'b111 and press_pulse=3'b111 for exactly 1 cycle.
- Clean press: key_in[0] rises before edge k. key_level[0]=1 and press_pulse[0]=1 at edge k+5; evt_pending[0]=1; evt_any=1 at k+6.
- Bounce rejection: key_in[1] pulses high for 3 cycles, low for 1, high for 3, then low. No press_pulse and key_level[1] stays 0. Next, input held high for 4+ cycles is accepted.
- Clear race: assert evt_clr[0] in the same cycle as press_pulse[0]. evt_pending[0] stays 1; evt_clr one cycle later clears it to 0.
- Long press and release: hold key_in[2] for 40 cycles.
  - long_press[2] rises 20 cycles after key_level[2].
  - On release: release_pulse[2]=1 and long_press[2]=0 on the same edge, 5 edges after the release sample.
- With BTN_AUTO_REPEAT_EN: the same 40-cycle hold produces extra press_pulse[2] at 8 and 16 cycles after long_press rises. Without the macro, exactly one press_pulse.
